// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the divider operand pre-normaliser.
package fp_div_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } res_class_t;

  // Width-independent part of an unpacked operand; consumers wrap it with sized fields.
  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
  } fp_unpacked_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports 0.
module fp_lzc #(
  parameter  int WIDTH = 24,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_div_prenorm.sv
// Two-stage operand pre-normaliser feeding the SRT divider: unpack, LZC and
// classify in S1; shift mantissas and form the pre-rounding exponent in S2.
module fp_div_prenorm
  import fp_div_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int SIG_W = MAN_W + 1,
  localparam int SH_W  = $clog2(MAN_W + 1),
  localparam int RE_W  = EXP_W + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           dividend,
  input  logic [W-1:0]           divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIG_W-1:0]       dvd_man,
  output logic [SIG_W-1:0]       dvs_man,
  output logic [SH_W-1:0]        dvd_shift,
  output logic [SH_W-1:0]        dvs_shift,
  output logic signed [RE_W-1:0] res_exp,
  output logic                   res_sign,
  output logic [1:0]             res_class,
  output logic                   div_by_zero
);

  localparam int DVD = 1;
  localparam int DVS = 0;
  localparam logic [RE_W-1:0] BIAS_V = RE_W'(bias(EXP_W));

  typedef struct packed {
    fp_unpacked_t         flg;
    logic [SIG_W-1:0]     sig;
    logic [EXP_W-1:0]     eexp;
  } op_t;

  typedef struct packed {
    logic [1:0][SIG_W-1:0] sig;
    logic [1:0][SH_W-1:0]  sh;
    logic [1:0][EXP_W-1:0] eexp;
    logic                  sign;
    res_class_t            cls;
    logic                  dbz;
  } s1_t;

  typedef struct packed {
    logic [1:0][SIG_W-1:0] man;
    logic [1:0][SH_W-1:0]  sh;
    logic [RE_W-1:0]       rexp;
    logic                  sign;
    res_class_t            cls;
    logic                  dbz;
  } s2_t;

  logic [1:0][W-1:0]    op_raw;
  op_t  [1:0]           op;
  logic [1:0][SH_W-1:0] lz;

  assign op_raw[DVD] = dividend;
  assign op_raw[DVS] = divisor;

  for (genvar g = 0; g < 2; g++) begin : g_op
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             e_zero, e_ones, f_zero;

    assign e      = op_raw[g][W-2 -: EXP_W];
    assign f      = op_raw[g][MAN_W-1:0];
    assign e_zero = (e == '0);
    assign e_ones = &e;
    assign f_zero = (f == '0);
    assign op[g]  = {op_raw[g][W-1], e_zero & f_zero, e_ones & f_zero, e_ones & ~f_zero,
                     ~e_zero, f, e_zero ? EXP_W'(1) : e};

    fp_lzc #(.WIDTH(SIG_W)) u_lzc (.din(op[g].sig), .cnt(lz[g]));
  end

  function automatic logic [RE_W-1:0] norm_exp(input logic [EXP_W-1:0] e,
                                                input logic [SH_W-1:0]  s);
    return RE_W'(e) - RE_W'(s);
  endfunction

  fp_unpacked_t a, b;
  logic         a_fin_nz;
  res_class_t   cls_in;
  logic         dbz_in;

  always_comb begin
    a        = op[DVD].flg;
    b        = op[DVS].flg;
    a_fin_nz = ~a.zero & ~a.inf & ~a.nan;
    cls_in   = CLS_NORMAL;
    dbz_in   = 1'b0;
    if (a.nan | b.nan | (a.zero & b.zero) | (a.inf & b.inf)) begin
      cls_in = CLS_NAN;
    end else if (a.inf | (a_fin_nz & b.zero)) begin
      cls_in = CLS_INF;
      dbz_in = a_fin_nz & b.zero;
    end else if (a.zero | b.inf) begin
      cls_in = CLS_ZERO;
    end
  end

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  always_comb begin
    s2_adv     = ~s2_valid_q | out_ready;
    s1_adv     = ~s1_valid_q | s2_adv;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

    // Data registers only load on a transfer so stalled stages hold steady.
    s1_d = s1_q;
    if (s1_adv && in_valid) begin
      for (int i = 0; i < 2; i++) begin
        s1_d.sig[i]  = op[i].sig;
        s1_d.sh[i]   = lz[i];
        s1_d.eexp[i] = op[i].eexp;
      end
      s1_d.sign = a.sign ^ b.sign;
      s1_d.cls  = cls_in;
      s1_d.dbz  = dbz_in;
    end

    s2_d = s2_q;
    if (s2_adv && s1_valid_q) begin
      for (int i = 0; i < 2; i++) begin
        s2_d.man[i] = s1_q.sig[i] << s1_q.sh[i];
        s2_d.sh[i]  = s1_q.sh[i];
      end
      s2_d.rexp = norm_exp(s1_q.eexp[DVD], s1_q.sh[DVD])
                - norm_exp(s1_q.eexp[DVS], s1_q.sh[DVS]) + BIAS_V;
      s2_d.sign = s1_q.sign;
      s2_d.cls  = s1_q.cls;
      s2_d.dbz  = s1_q.dbz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign in_ready    = s1_adv;
  assign out_valid   = s2_valid_q;
  assign dvd_man     = s2_q.man[DVD];
  assign dvs_man     = s2_q.man[DVS];
  assign dvd_shift   = s2_q.sh[DVD];
  assign dvs_shift   = s2_q.sh[DVS];
  assign res_exp     = $signed(s2_q.rexp);
  assign res_sign    = s2_q.sign;
  assign res_class   = s2_q.cls;
  assign div_by_zero = s2_q.dbz;

endmodule

// File: tb/tb_fp_div_prenorm.sv
// Directed and randomised bench for fp_div_prenorm with a queue scoreboard.
module tb_fp_div_prenorm;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [31:0]        dividend, divisor;
  logic [23:0]        dvd_man, dvs_man;
  logic [4:0]         dvd_shift, dvs_shift;
  logic signed [9:0]  res_exp;
  logic               res_sign, div_by_zero;
  logic [1:0]         res_class;

  fp_div_prenorm #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .dvd_man(dvd_man), .dvs_man(dvs_man), .dvd_shift(dvd_shift), .dvs_shift(dvs_shift),
    .res_exp(res_exp), .res_sign(res_sign), .res_class(res_class), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] dm, vm;
    logic [4:0]  ds, vs;
    logic [9:0]  re;
    logic        sg;
    logic [1:0]  cl;
    logic        dz;
  } res_t;

  int   n_cmp = 0, n_bad = 0;
  res_t q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t dut_out();
    return {dvd_man, dvs_man, dvd_shift, dvs_shift, res_exp, res_sign, res_class, div_by_zero};
  endfunction

  function automatic void norm(input logic [31:0] x, output logic [23:0] m,
                               output int sh, output int e);
    m  = {x[30:23] != 8'd0, x[22:0]};
    sh = 0;
    if (m != 24'd0) while (!m[23]) begin m = m << 1; sh++; end
    e  = ((x[30:23] == 8'd0) ? 1 : int'(x[30:23])) - sh;
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    int   sa, sb, ea, eb;
    logic na, nb, ia, ib, za, zb;
    norm(a, r.dm, sa, ea);
    norm(b, r.vm, sb, eb);
    r.ds = 5'(sa);
    r.vs = 5'(sb);
    r.re = 10'(ea - eb + 127);
    r.sg = a[31] ^ b[31];
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    za = (a[30:0] == 0);
    zb = (b[30:0] == 0);
    r.dz = 1'b0;
    if (na || nb || (za && zb) || (ia && ib)) r.cl = 2'd3;
    else if (ia || zb) begin r.cl = 2'd2; r.dz = !ia; end
    else if (za || ib) r.cl = 2'd1;
    else r.cl = 2'd0;
    return r;
  endfunction

  // Scoreboard / protocol monitor, sampling mid-cycle.
  logic stalled = 1'b0;
  res_t held;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", dut_out(), held);
      end
      if (out_valid) begin
        chk("out_has_pending", q.size() > 0, 1);
        if (out_ready && q.size() > 0) chk("scoreboard", dut_out(), q.pop_front());
      end
      stalled = out_valid && !out_ready;
      held    = dut_out();
      if (in_valid && in_ready) q.push_back(model(dividend, divisor));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    logic acc = 1'b0;
    in_valid = 1'b1; dividend = a; divisor = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic one(input logic [31:0] a, input logic [31:0] b, output res_t got);
    int cyc = 0;
    send(a, b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
      cyc++;
    end
    got = dut_out();
    chk("latency", cyc, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : (23'($urandom) >> $urandom_range(0, 22));
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] sa[8] = '{32'h3F800000, 32'h00000001, 32'hC0C00000, 32'h00000000,
                         32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h40490FDB};
  logic [31:0] sb[8] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h00000000,
                         32'h7F800000, 32'h40000000, 32'h40400000, 32'h807FFFFF};

  initial begin
    res_t got;
    logic done;
    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", dut_out(), 0);
    @(posedge clk); #1;

    one(32'h3F800000, 32'h3F800000, got);
    chk("one_one", got, {24'h800000, 24'h800000, 5'd0, 5'd0, 10'd127, 1'b0, 2'd0, 1'b0});
    one(32'h00000001, 32'h3F800000, got);
    chk("subn_man", got.dm, 24'h800000);
    chk("subn_shift", got.ds, 5'd23);
    chk("subn_exp", got.re, 10'h3EA);
    chk("subn_cls", got.cl, 2'd0);
    one(32'hC0C00000, 32'h00000000, got);
    chk("dbz_flags", {got.sg, got.cl, got.dz}, {1'b1, 2'd2, 1'b1});
    one(32'h00000000, 32'h00000000, got);
    chk("zz_nan", {got.cl, got.dz}, {2'd3, 1'b0});
    one(32'h7F800000, 32'h7F800000, got);
    chk("ii_nan", got.cl, 2'd3);
    one(32'h7FC00000, 32'h40000000, got);
    chk("qnan", got.cl, 2'd3);
    one(32'h00000000, 32'h40400000, got);
    chk("zero_res", {got.cl, got.dz}, {2'd1, 1'b0});

    // Back-to-back stream with out_ready pattern 1,0,0,1.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(sa[i], sb[i]);
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 200 && !done; k++) begin
          out_ready = (k % 4 == 0) || (k % 4 == 3);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stream_drain", q.size(), 0);
    @(posedge clk); #1;

    // Reset with two pairs in flight.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000);
    send(32'h40400000, 32'h3F800000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // Randomised operands and backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) send(rnd_op(), rnd_op());
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 5000 && !done; k++) begin
          out_ready = 1'($urandom);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rand_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_div_prenorm.md
# fp_div_prenorm

Parametrised, pipelined operand pre-normaliser for the SRT divider. Accepts a dividend/divisor pair of IEEE-754-style floats of configurable width under a valid/ready handshake. Unpacks both operands, normalises subnormals via leading-zero count, and classifies special operands. Emits normalised mantissas, a signed pre-rounding result exponent, the result sign and an operand class to the SRT iteration stage two cycles later.

## Interface
- `EXP_W`, default 8: exponent field width; bias `BIAS = 2^(EXP_W-1)-1`.
- `MAN_W`, default 23: stored fraction width; normalised mantissa is `MAN_W+1` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair this cycle.
- `dividend`, `divisor`  in  `1+EXP_W+MAN_W` each  packed floats: sign, exponent, fraction.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `dvd_man`, `dvs_man`  out  `MAN_W+1` each  normalised mantissas; MSB = 1 unless the operand is zero.
- `dvd_shift`, `dvs_shift`  out  `$clog2(MAN_W+1)` each  left-shift applied.
- `res_exp`  out  `EXP_W+2` signed  pre-rounding biased result exponent.
- `res_sign`  out  1  dividend sign XOR divisor sign.
- `res_class`  out  2  NORMAL=0, ZERO=1, INF=2, NAN=3.
- `div_by_zero`  out  1  finite nonzero dividend, zero divisor.

## Operation
- Unpack: `hidden = (exp != 0)`; `sig = {hidden, frac}`; `eff_exp = (exp == 0) ? 1 : exp`, extended to `EXP_W+2` signed.
- Normalise: `shift = lzc(sig)`; `man = sig << shift`; `eff_exp -= shift`. For `sig == 0`: shift 0, man 0.
- Exponent: `res_exp = eff_exp_dvd - eff_exp_dvs + BIAS`. Computed in `EXP_W+2` signed; no saturation, because overflow/underflow is resolved after the quotient.
- Classification, in priority order:
  - NAN: either operand NaN (exp all-ones, frac != 0), 0/0 or inf/inf.
  - INF: inf/finite, or finite nonzero / 0; `div_by_zero` = 1 only for the latter.
  - ZERO: 0/finite-nonzero, or finite/inf.
  - NORMAL: otherwise.
- Mantissa, shift and exponent outputs are still driven for non-NORMAL classes, computed by the same rules. Downstream ignores them.
- `res_sign` is always the XOR, including for NAN.

## Timing
- Two-stage pipeline.
  - S1 registers the unpacked fields, LZC results and class.
  - S2 registers the shifted mantissas and `res_exp`.
- Latency: exactly 2 cycles from an accepted input to `out_valid` when `out_ready` stays high. Throughput is 1 pair per cycle.
- Advance rules: `s2_adv = !s2_valid || out_ready`; `s1_adv = !s1_valid || s2_adv`; `in_ready = s1_adv`, combinational, with no dependency on `in_valid`.
- Transfer occurs when valid && ready. Stalled stages hold all data bits stable. `out_valid` never drops without a transfer.
- Input and output transfers may occur in the same cycle; the pipeline remains full.
- Reset: `s1_valid`, `s2_valid` and `out_valid` = 0. All data outputs = 0 and `res_class` = NORMAL. `in_ready` = 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight pairs; no partial output appears.

## Structure
- Package `fp_div_pkg`:
  - `res_class_t` enum (2-bit);
  - `fp_unpacked_t` struct, parametrised by typedef in the consumer;
  - `BIAS` function of `EXP_W`.
- Sub-module `fp_lzc`: parametrised combinational leading-zero counter, `WIDTH` → count of `$clog2(WIDTH)` bits; all-zero input returns 0. Instantiated twice in S1.
- Top level holds the pipeline registers, handshake logic and classifier.

## Test plan
All values use the default parameters.
- 1.0/1.0 (`0x3F800000`, `0x3F800000`) → after 2 cycles: man `0x800000` ×2, shifts 0, `res_exp` 127, sign 0, NORMAL.
- `0x00000001` / `0x3F800000` → `dvd_man` `0x800000`, `dvd_shift` 23, `res_exp` -22, NORMAL.
- -6.0/0.0 (`0xC0C00000`, `0x00000000`) → INF, `div_by_zero` 1, sign 1. Then 0/0 → NAN with `div_by_zero` 0; inf/inf → NAN; `0x7FC00000`/2.0 → NAN; 0/3.0 → ZERO.
- Back-to-back stream of 8 pairs with `out_ready` toggling 1,0,0,1,… → outputs in order, no loss or duplication. Data holds stable while stalled. `in_ready` = 0 exactly when both stages are full and `out_ready` = 0.
- Assert `rst` with two pairs in flight → next cycle `out_valid` = 0 and `in_ready` = 1. No stale output appears afterwards.
- Randomised operands against a reference model → bit-exact on all outputs.
